uart_rx: RTL and testbench

// - AXI4-Stream UART receiver; the receive-side peer of the UART transmitter.
// - Deserialises an async 8N1-style line (start, DATA_WIDTH data bits LSB-first, 1 stop) into AXI4-Stream words.
// - Bit period = prescale*8 clk cycles; uses the same prescale encoding as the transmitter, so equal prescale values interoperate.
// - Flags framing and overrun errors.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with an AXI4-Stream master output.
// Deserialises a start / DATA_WIDTH data bits (LSB first) / stop line into
// words. The bit period is prescale*8 clk cycles, the same encoding the
// matching transmitter uses. Each bit is sampled at its centre.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   m_axis_tdata      received word
//   m_axis_tvalid     word valid
//   m_axis_tready     downstream ready
//   rxd               asynchronous serial input, idle high
//   busy              a frame is being received, or a break is in progress
//   overrun_error     1-cycle pulse: an unconsumed word was overwritten
//   frame_error       1-cycle pulse: the stop bit was sampled low
//   prescale          bit period = prescale*8 cycles; latched at start detect
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t                r_state;
  logic                  r_rx_meta;
  logic                  r_rxs;
  logic [18:0]           r_cnt;
  logic [15:0]           r_prescale;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;

  logic [18:0] w_half_period;
  logic [18:0] w_bit_period;
  logic        w_last_bit;
  logic        w_handshake;

  // The half period comes from the live input because it is loaded on the same
  // cycle prescale is latched; full periods use the latched copy so a
  // mid-frame prescale change has no effect.
  assign w_half_period = {1'b0, prescale, 2'b00} - 19'd1;
  assign w_bit_period  = {r_prescale, 3'b000} - 19'd1;
  assign w_last_bit    = (r_bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign w_handshake   = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rx_meta     <= 1'b1;
      r_rxs         <= 1'b1;
      r_cnt         <= '0;
      r_prescale    <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      r_rx_meta     <= rxd;
      r_rxs         <= r_rx_meta;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;

      // A completing frame below overrides this clear, so a word that finishes
      // on a handshake cycle replaces the consumed one with tvalid kept high.
      if (w_handshake) m_axis_tvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          if (!r_rxs && prescale != 16'd0) begin
            r_prescale <= prescale;
            r_cnt      <= w_half_period;
            r_state    <= S_START;
            busy       <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt != 19'd0) begin
            r_cnt <= r_cnt - 19'd1;
          end else if (!r_rxs) begin
            r_cnt     <= w_bit_period;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            // Line went back high before the start-bit centre: a glitch.
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        S_DATA: begin
          if (r_cnt != 19'd0) begin
            r_cnt <= r_cnt - 19'd1;
          end else begin
            r_shift   <= {r_rxs, r_shift[DATA_WIDTH-1:1]};
            r_bit_idx <= r_bit_idx + IDX_W'(1);
            r_cnt     <= w_bit_period;
            if (w_last_bit) r_state <= S_STOP;
          end
        end

        S_STOP: begin
          if (r_cnt != 19'd0) begin
            r_cnt <= r_cnt - 19'd1;
          end else if (r_rxs) begin
            m_axis_tdata  <= r_shift;
            m_axis_tvalid <= 1'b1;
            if (m_axis_tvalid && !m_axis_tready) overrun_error <= 1'b1;
            // Re-arm immediately so a start edge in the back half of the stop
            // bit is still caught.
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            frame_error <= 1'b1;
            r_state     <= S_BREAK;
          end
        end

        S_BREAK: begin
          busy <= 1'b1;
          if (r_rxs) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed stimulus for uart_rx. A line driver
// serialises frames bit by bit and pushes each expected word into a queue; an
// independent monitor pops and compares on every AXI handshake and counts
// error pulses and busy/tvalid edges.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        rxd = 1'b1;
  logic        busy;
  logic        overrun_error;
  logic        frame_error;
  logic [15:0] prescale = 16'd1;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .prescale      (prescale)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] sb[$];
  int pops = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_rise = -1, busy_fall = -1, busy_rises = 0;
  int tv_rise = -1, tv_fall = -1;
  logic busy_q = 1'b0, tv_q = 1'b0;
  int rdy_mode = 1; // 0: low, 1: high, 2: random

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: scoreboard pops plus pulse/edge bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", m_axis_tdata);
        end else begin
          chk("word", int'(m_axis_tdata), int'(sb.pop_front()));
        end
        pops++;
      end
      if (frame_error) fe_cnt++;
      if (overrun_error) ov_cnt++;
      if (busy && !busy_q) begin busy_rise = cyc; busy_rises++; end
      if (!busy && busy_q) busy_fall = cyc;
      if (m_axis_tvalid && !tv_q) tv_rise = cyc;
      if (!m_axis_tvalid && tv_q) tv_fall = cyc;
    end
    busy_q = busy;
    tv_q = m_axis_tvalid;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one good frame; expectation queued up front since tvalid rises
  // before the stop bit ends.
  task automatic send_frame(input logic [7:0] d, input int p, input bit jitter);
    prescale = 16'(p);
    sb.push_back(d);
    rxd = 1'b0;
    hold(8 * p);
    if (jitter) prescale = 16'($urandom_range(1, 5));
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      hold(8 * p);
    end
    rxd = 1'b1;
    hold(8 * p);
  endtask

  initial begin
    int d0, p0, fe0, ov0, pop0, br0;
    logic [7:0] v;
    hold(4);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun_error), 0);
    chk("rst_frame_err", int'(frame_error), 0);
    rst = 1'b0;
    hold(5);

    // Frame 0xA5, prescale 1: exact latency and busy window.
    d0 = cyc;
    send_frame(8'hA5, 1, 1'b0);
    hold(4);
    chk("a5_busy_rise", busy_rise - d0, 3);
    chk("a5_busy_fall", busy_fall - d0, 79);
    chk("a5_tvalid_rise", tv_rise - d0, 79);
    chk("a5_tvalid_fall", tv_fall - d0, 80);
    chk("a5_pops", pops, 1);

    // Start glitch: two low cycles.
    fe0 = fe_cnt; ov0 = ov_cnt; pop0 = pops;
    d0 = cyc;
    rxd = 1'b0;
    hold(2);
    rxd = 1'b1;
    hold(20);
    chk("glitch_busy_rise", busy_rise - d0, 3);
    chk("glitch_busy_fall", busy_fall - d0, 7);
    chk("glitch_pops", pops, pop0);
    chk("glitch_errs", fe_cnt + ov_cnt, fe0 + ov0);

    // Framing error: 0x3C at prescale 2 with the stop bit held low.
    fe0 = fe_cnt; pop0 = pops;
    prescale = 16'd2;
    rxd = 1'b0;
    hold(16);
    for (int i = 0; i < 8; i++) begin
      v = 8'h3C;
      rxd = v[i];
      hold(16);
    end
    rxd = 1'b0;
    hold(20);
    chk("break_busy", int'(busy), 1);
    chk("break_fe_pulse", fe_cnt - fe0, 1);
    rxd = 1'b1;
    hold(6);
    chk("break_busy_clear", int'(busy), 0);
    chk("break_no_word", pops, pop0);
    hold(10);

    // Overrun: tready low across two frames.
    ov0 = ov_cnt; pop0 = pops;
    rdy_mode = 0;
    hold(1);
    send_frame(8'h11, 1, 1'b0);
    send_frame(8'h22, 1, 1'b0);
    chk("ovr_pulse", ov_cnt - ov0, 1);
    chk("ovr_tdata", int'(m_axis_tdata), 8'h22);
    chk("ovr_tvalid", int'(m_axis_tvalid), 1);
    void'(sb.pop_front()); // 0x11 was overwritten and is lost
    rdy_mode = 1;
    hold(6);
    chk("ovr_one_xfer", pops - pop0, 1);
    chk("ovr_tvalid_clear", int'(m_axis_tvalid), 0);

    // Back-to-back frames with no idle gap.
    pop0 = pops;
    send_frame(8'h00, 1, 1'b0);
    send_frame(8'hFF, 1, 1'b0);
    send_frame(8'h5A, 1, 1'b0);
    hold(4);
    chk("b2b_pops", pops - pop0, 3);
    chk("b2b_tdata", int'(m_axis_tdata), 8'h5A);

    // prescale 0: receiver ignores the line.
    br0 = busy_rises;
    prescale = 16'd0;
    rxd = 1'b0;
    hold(50);
    rxd = 1'b1;
    hold(5);
    chk("p0_no_busy", busy_rises, br0);

    // Reset in the middle of frame 0x81, then a clean 0x42.
    prescale = 16'd1;
    pop0 = pops; fe0 = fe_cnt;
    rxd = 1'b0; hold(8);
    rxd = 1'b1; hold(8);
    rxd = 1'b0; hold(8);
    rst = 1'b1;
    rxd = 1'b1;
    hold(2);
    chk("mid_rst_tdata", int'(m_axis_tdata), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_tvalid", int'(m_axis_tvalid), 0);
    rst = 1'b0;
    hold(10);
    chk("mid_rst_idle", int'(busy), 0);
    send_frame(8'h42, 1, 1'b0);
    hold(4);
    chk("mid_rst_only_42", pops - pop0, 1);
    chk("mid_rst_no_fe", fe_cnt, fe0);

    // Randomized frames, prescale, gaps, mid-frame prescale changes, tready.
    fe0 = fe_cnt; ov0 = ov_cnt;
    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      p0 = $urandom_range(1, 3);
      send_frame(8'($urandom_range(0, 255)), p0, ($urandom_range(0, 1) == 1));
      hold($urandom_range(0, 10));
    end
    rdy_mode = 1;
    for (int i = 0; i < 2000 && sb.size() != 0; i++) hold(1);
    hold(4);
    chk("drain", sb.size(), 0);
    chk("rand_no_fe", fe_cnt, fe0);
    chk("rand_no_ov", ov_cnt, ov0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
